// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC receive/transmit paths.
package mac_pkg;

    localparam logic [7:0]  PREAMBLE_DATA  = 8'h55;
    localparam logic [7:0]  SFD_DATA       = 8'hD5;
    localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB_20E3;
    localparam logic [31:0] CRC_POLY       = 32'hEDB8_8320;
    localparam logic [47:0] BROADCAST_ADDR = 48'hFFFF_FFFF_FFFF;
    localparam int          LEN_W          = 11;
    localparam int          DLY_DEPTH      = 5;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_state_t;

endpackage

// File: rtl/mac_crc32_d8.sv
// Byte-wide Ethernet CRC-32 update (reflected, LSB first), shared by RX and TX.
module mac_crc32_d8
    import mac_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            crc_out = (crc_out >> 1) ^ ((crc_out[0] ^ data[i]) ? CRC_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/mac_decap.sv
// GMII receive decapsulator: strips preamble/SFD/FCS, checks CRC/length/errors, filters DA.
//   state    | meaning
//   IDLE     | waiting for rxdv
//   PREAMBLE | receiving 0x55 bytes, waiting for SFD
//   DATA     | frame bytes DA..FCS, delay line feeding output
//   DROP     | discarding until rxdv drops
module mac_decap
    import mac_pkg::*;
#(
    parameter int MIN_FRAME_LENGTH = 64,
    parameter int MAX_FRAME_LENGTH = 1518
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_ce,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rxdv,
    input  logic        gmii_rxer,
    input  logic [47:0] mac_address,
    input  logic        promiscuous,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    output logic        m_tuser,
    output logic        frame_good,
    output logic        frame_bad,
    output logic        frame_dropped
);

    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_MIN_FRAME = LEN_W'(MIN_FRAME_LENGTH);
    localparam logic [LEN_W-1:0] LEN_MAX_FRAME = LEN_W'(MAX_FRAME_LENGTH);

    rx_state_t                       state, state_next;
    logic [LEN_W-1:0]                len;
    logic [DLY_DEPTH-1:0][7:0]       dly;
    logic [31:0]                     crc, crc_next;
    logic                            rxer_seen;
    logic                            addr_ok;
    logic                            addr_pass;
    logic                            deliver;
    logic                            frame_is_bad;
    logic [47:0]                     da;

    mac_crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (gmii_rxd),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (rx_ce) begin
            case (state)
                IDLE: begin
                    if (gmii_rxdv) begin
                        if (gmii_rxd == PREAMBLE_DATA) state_next = PREAMBLE;
                        else if (gmii_rxd == SFD_DATA) state_next = DATA;
                        else                           state_next = DROP;
                    end
                end
                PREAMBLE: begin
                    if (!gmii_rxdv)                     state_next = IDLE;
                    else if (gmii_rxer)                 state_next = DROP;
                    else if (gmii_rxd == PREAMBLE_DATA) state_next = PREAMBLE;
                    else if (gmii_rxd == SFD_DATA)      state_next = DATA;
                    else                                state_next = DROP;
                end
                DATA:    if (!gmii_rxdv) state_next = IDLE;
                DROP:    if (!gmii_rxdv) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // DA is complete when byte 5 arrives: bytes 0..4 sit in the delay line, byte 0 oldest.
    always_comb begin
        da           = {dly, gmii_rxd};
        addr_pass    = (da == mac_address) || (da == BROADCAST_ADDR) || dly[4][0] || promiscuous;
        deliver      = (len == LEN_W'(5)) ? addr_pass : addr_ok;
        frame_is_bad = (crc != CRC_RESIDUE) || rxer_seen ||
                       (len < LEN_MIN_FRAME) || (len > LEN_MAX_FRAME);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len           <= '0;
            dly           <= '0;
            crc           <= CRC_INIT;
            rxer_seen     <= 1'b0;
            addr_ok       <= 1'b0;
            m_tdata       <= '0;
            m_tvalid      <= 1'b0;
            m_tlast       <= 1'b0;
            m_tuser       <= 1'b0;
            frame_good    <= 1'b0;
            frame_bad     <= 1'b0;
            frame_dropped <= 1'b0;
        end else begin
            m_tvalid      <= 1'b0;
            m_tlast       <= 1'b0;
            m_tuser       <= 1'b0;
            frame_good    <= 1'b0;
            frame_bad     <= 1'b0;
            frame_dropped <= 1'b0;
            if (rx_ce) begin
                if (state != DATA && state_next == DATA) begin
                    len       <= '0;
                    crc       <= CRC_INIT;
                    rxer_seen <= 1'b0;
                    addr_ok   <= 1'b0;
                end else if (state == DATA && gmii_rxdv) begin
                    crc <= crc_next;
                    dly <= {dly[DLY_DEPTH-2:0], gmii_rxd};
                    if (len != LEN_MAX) len <= len + LEN_W'(1);
                    if (gmii_rxer) rxer_seen <= 1'b1;
                    if (len == LEN_W'(5)) addr_ok <= addr_pass;
                    if (len >= LEN_W'(5) && deliver) begin
                        m_tdata  <= dly[4];
                        m_tvalid <= 1'b1;
                    end
                end else if (state == DATA) begin
                    // rxdv dropped: the oldest held byte is the last non-FCS byte
                    if (len < LEN_W'(6) || !addr_ok) begin
                        frame_dropped <= 1'b1;
                    end else begin
                        m_tdata    <= dly[4];
                        m_tvalid   <= 1'b1;
                        m_tlast    <= 1'b1;
                        m_tuser    <= frame_is_bad;
                        frame_good <= !frame_is_bad;
                        frame_bad  <= frame_is_bad;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_decap.sv
// Randomized frame stimulus for mac_decap checked against a frame-level reference model.
module tb_mac_decap;

    localparam logic [47:0] MAC   = 48'h00_0A_35_01_02_03;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_99;
    localparam logic [47:0] NEAR  = 48'h00_0A_35_01_02_02;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_ce;
    logic [7:0]  gmii_rxd;
    logic        gmii_rxdv;
    logic        gmii_rxer;
    logic [47:0] mac_address;
    logic        promiscuous;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tlast, m_tuser;
    logic        frame_good, frame_bad, frame_dropped;

    always #4 clk = ~clk;

    mac_decap #(.MIN_FRAME_LENGTH(64), .MAX_FRAME_LENGTH(1518)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_ce         (rx_ce),
        .gmii_rxd      (gmii_rxd),
        .gmii_rxdv     (gmii_rxdv),
        .gmii_rxer     (gmii_rxer),
        .mac_address   (mac_address),
        .promiscuous   (promiscuous),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tlast       (m_tlast),
        .m_tuser       (m_tuser),
        .frame_good    (frame_good),
        .frame_bad     (frame_bad),
        .frame_dropped (frame_dropped)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Observed beats; last-beat code is {m_tuser, frame_good, frame_bad} in the tlast clk
    logic [7:0] act_d[$];
    bit         act_l[$];
    logic [2:0] act_code[$];
    int         act_good = 0, act_bad = 0, act_drop = 0;

    logic [7:0] exp_d[$];
    bit         exp_l[$];
    logic [2:0] exp_code[$];
    int         exp_good = 0, exp_bad = 0, exp_drop = 0;

    always @(negedge clk) begin
        if (m_tvalid === 1'b1) begin
            act_d.push_back(m_tdata);
            act_l.push_back(m_tlast);
            if (m_tlast) act_code.push_back({m_tuser, frame_good, frame_bad});
        end
        if (frame_good === 1'b1)    act_good++;
        if (frame_bad === 1'b1)     act_bad++;
        if (frame_dropped === 1'b1) act_drop++;
    end

    logic [7:0] fr[$];
    bit         ce_rand = 1'b0;

    function automatic logic [31:0] crc_of(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, fr[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic make_frame(input logic [47:0] da, input int len, input bit fcs_ok);
        logic [31:0] c;
        fr.delete();
        for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
        if (len >= 6) for (int i = 0; i < 6; i++) fr[i] = da[47-8*i -: 8];
        if (len >= 10 && fcs_ok) begin
            c = crc_of(len - 4);
            for (int i = 0; i < 4; i++) fr[len-4+i] = c[8*i +: 8];
        end
    endtask

    // Reference: L-4 bytes delivered unless runt (<6) or filtered; bad from FCS/rxer/length rules
    task automatic model_frame(input bit rxer_hit);
        int          l;
        logic [47:0] da;
        bit          pass, bad;
        l = fr.size();
        if (l < 6) begin
            exp_drop++;
            return;
        end
        da   = {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]};
        pass = (da == mac_address) || (da == BCAST) || fr[0][0] || promiscuous;
        if (!pass) begin
            exp_drop++;
            return;
        end
        bad = rxer_hit || (l < 64) || (l > 1518) || (l < 10) ||
              (crc_of(l - 4) != {fr[l-1], fr[l-2], fr[l-3], fr[l-4]});
        for (int i = 0; i <= l - 5; i++) begin
            exp_d.push_back(fr[i]);
            exp_l.push_back(i == l - 5);
        end
        exp_code.push_back(bad ? 3'b101 : 3'b010);
        if (bad) exp_bad++;
        else     exp_good++;
    endtask

    task automatic put(input logic [7:0] d, input logic dv, input logic er);
        if (ce_rand) begin
            while ($urandom_range(0, 2) == 0) begin
                rx_ce     = 1'b0;
                gmii_rxd  = 8'($urandom);
                gmii_rxdv = 1'($urandom);
                gmii_rxer = 1'($urandom);
                @(posedge clk); #1;
            end
        end
        rx_ce     = 1'b1;
        gmii_rxd  = d;
        gmii_rxdv = dv;
        gmii_rxer = er;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int n_pre, input int rxer_at, input int rst_at, input int gap);
        for (int i = 0; i < n_pre; i++) put(8'h55, 1'b1, 1'b0);
        put(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < fr.size(); i++) begin
            if (i == rst_at) begin
                reset = 1'b1;
                put(fr[i], 1'b1, 1'b0);
                reset = 1'b0;
            end else begin
                put(fr[i], 1'b1, 1'(i == rxer_at));
            end
        end
        for (int i = 0; i < gap; i++) put(8'h00, 1'b0, 1'b0);
    endtask

    task automatic settle_and_compare(input string tag);
        int n, e0;
        rx_ce     = 1'b1;
        gmii_rxdv = 1'b0;
        gmii_rxer = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq({tag, " beats"}, act_d.size(), exp_d.size());
        n  = (act_d.size() < exp_d.size()) ? act_d.size() : exp_d.size();
        e0 = n_err;
        for (int i = 0; i < n && n_err == e0; i++) begin
            check_eq({tag, " data"}, act_d[i], exp_d[i]);
            check_eq({tag, " tlast"}, act_l[i], exp_l[i]);
        end
        check_eq({tag, " frames"}, act_code.size(), exp_code.size());
        n = (act_code.size() < exp_code.size()) ? act_code.size() : exp_code.size();
        for (int i = 0; i < n; i++) check_eq({tag, " tuser/good/bad"}, act_code[i], exp_code[i]);
        check_eq({tag, " n_good"}, act_good, exp_good);
        check_eq({tag, " n_bad"}, act_bad, exp_bad);
        check_eq({tag, " n_dropped"}, act_drop, exp_drop);
        act_d.delete(); act_l.delete(); act_code.delete();
        exp_d.delete(); exp_l.delete(); exp_code.delete();
    endtask

    task automatic one_frame(input string tag, input logic [47:0] da, input int len, input bit fcs_ok,
                             input int rxer_at);
        make_frame(da, len, fcs_ok);
        model_frame(rxer_at >= 0 && rxer_at < len);
        send_frame(7, rxer_at, -1, 1);
        settle_and_compare(tag);
    endtask

    initial begin
        reset       = 1'b1;
        rx_ce       = 1'b1;
        gmii_rxd    = 8'h00;
        gmii_rxdv   = 1'b0;
        gmii_rxer   = 1'b0;
        mac_address = MAC;
        promiscuous = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset outputs",
                 {18'h0, m_tdata, m_tvalid, m_tlast, m_tuser, frame_good, frame_bad, frame_dropped}, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        one_frame("good unicast", MAC, 68, 1'b1, -1);

        make_frame(MAC, 68, 1'b1);
        fr[30] = fr[30] ^ 8'h04;
        model_frame(1'b0);
        send_frame(7, -1, -1, 1);
        settle_and_compare("bit flip");

        one_frame("filtered", OTHER, 70, 1'b1, -1);
        one_frame("near miss DA", NEAR, 70, 1'b1, -1);
        promiscuous = 1'b1;
        one_frame("promiscuous", OTHER, 70, 1'b1, -1);
        promiscuous = 1'b0;
        one_frame("broadcast", BCAST, 80, 1'b1, -1);
        one_frame("multicast", MCAST, 80, 1'b1, -1);

        one_frame("runt 40", MAC, 40, 1'b1, -1);
        one_frame("len 3", MAC, 3, 1'b1, -1);
        one_frame("len 5", MAC, 5, 1'b1, -1);
        one_frame("len 6", MAC, 6, 1'b1, -1);
        one_frame("len 63", MAC, 63, 1'b1, -1);
        one_frame("len 64", MAC, 64, 1'b1, -1);
        one_frame("len 1518", MAC, 1518, 1'b1, -1);
        one_frame("len 1519", MAC, 1519, 1'b1, -1);
        one_frame("len 2100", MAC, 2100, 1'b1, -1);

        // rxer frame immediately followed by a good frame after one idle cycle
        make_frame(MAC, 100, 1'b1);
        model_frame(1'b1);
        send_frame(7, 40, -1, 1);
        make_frame(MAC, 72, 1'b1);
        model_frame(1'b0);
        send_frame(0, -1, -1, 1);
        settle_and_compare("rxer then back-to-back");

        // reset at payload byte 20 (frame byte 34); next sampled byte is not preamble/SFD
        make_frame(MAC, 90, 1'b1);
        fr[35] = 8'h00;
        for (int i = 0; i <= 34 - 6; i++) begin
            exp_d.push_back(fr[i]);
            exp_l.push_back(1'b0);
        end
        send_frame(7, -1, 34, 1);
        make_frame(MAC, 66, 1'b1);
        model_frame(1'b0);
        send_frame(7, -1, -1, 1);
        settle_and_compare("reset mid-frame");

        for (int t = 0; t < 40; t++) begin
            logic [47:0] da;
            int          len, rx_at, sel;
            sel = $urandom_range(0, 4);
            da  = (sel == 0) ? MAC : (sel == 1) ? BCAST : (sel == 2) ? MCAST :
                  (sel == 3) ? OTHER : NEAR;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 200);
            rx_at       = ($urandom_range(0, 6) == 0) ? $urandom_range(0, len - 1) : -1;
            promiscuous = ($urandom_range(0, 4) == 0);
            ce_rand     = 1'($urandom);
            make_frame(da, len, $urandom_range(0, 3) != 0);
            model_frame(rx_at >= 0);
            send_frame($urandom_range(0, 7), rx_at, -1, $urandom_range(1, 4));
            ce_rand = 1'b0;
            settle_and_compare("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
